// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, the instruction
// memory itself and the bench: memory geometry and the loader state set.
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: the inbound instruction stream (valid/ready) and the outbound
// instruction-memory write port. The slave modport is the loader's view;
// the master modport is the view of the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// Zero-fills the instruction memory, then writes a streamed program into it
// sequentially and releases the CPU start once the final write has landed.
// Memory port is registered (one cycle after the generating cycle); the
// stream is only accepted in LOAD, stalls are unbounded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [ADDR_W:0]   word_count_i,
  imem_loader_if.slave      bus,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic              err_o
);

  // Counter is one bit wider than the address so a full-depth load ends
  // without wrapping.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  ldr_state_e        r_state, w_state_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W:0]   r_target, w_target_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_err, w_err_nxt;
  logic              r_start, w_start_nxt;
  logic              w_ready;
  logic              w_hs;

  assign w_ready = (r_state == ST_LOAD);
  assign w_hs    = w_ready && bus.s_valid_i;

  assign bus.s_ready_o  = w_ready;
  assign bus.mem_we_o   = r_we;
  assign bus.mem_addr_o = r_addr;
  assign bus.mem_data_o = r_data;
  assign cpu_start_o    = r_start;
  assign busy_o         = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
  assign err_o          = r_err;

  // Next state plus next values of the counter and the registered memory port.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_err_nxt    = r_err;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load_req_i) begin
          w_target_nxt = (word_count_i > DEPTH_C) ? DEPTH_C : word_count_i;
          w_err_nxt    = (word_count_i > DEPTH_C);
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt[ADDR_W-1:0];
        w_data_nxt = '0;
        if (r_cnt == LAST_C) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_target != '0) ? ST_LOAD : ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_cnt[ADDR_W-1:0];
          w_data_nxt = bus.s_data_i;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == (r_target - 1'b1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Start rises one cycle after DONE is entered, so the last write has
    // already been presented; it drops as soon as DONE is left.
    w_start_nxt = (r_state == ST_DONE) && (w_state_nxt == ST_DONE);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, target, error flag, start flag and registered memory port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_target <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
      r_start  <= w_start_nxt;
    end
  end

endmodule
